// File: rtl/gpo_seq_pkg.sv
// gpo_seq_pkg
//   Shared definitions for the GPO pattern sequencer: bus register offsets,
//   CTRL bit positions, STATUS field positions and the sequencer state enum.
package gpo_seq_pkg;

  // Word register offsets on the slave bus
  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_STATUS = 3'd1;
  localparam logic [2:0] ADDR_DWELL  = 3'd2;
  localparam logic [2:0] ADDR_LEN    = 3'd3;
  localparam logic [2:0] ADDR_PTR    = 3'd4;
  localparam logic [2:0] ADDR_PAT    = 3'd5;

  // CTRL bit positions (START and STOP are write-1 pulses, never stored)
  localparam int CTRL_START  = 0;
  localparam int CTRL_LOOP   = 1;
  localparam int CTRL_STOP   = 2;
  localparam int CTRL_IRQ_EN = 3;

  // STATUS field positions
  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_IDX_LSB = 8;

  // Width of the LEN register (enough to hold a step count of 256)
  localparam int LEN_W = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DWELL = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/gpo_seq_pat_mem.sv
// gpo_seq_pat_mem
//   DEPTH x 8 pattern register file. One synchronous write port, two
//   asynchronous read ports: port A feeds the sequencer (step index), port B
//   feeds bus read-back (PTR). No reset; contents are undefined until written.
// Ports:
//   clk      system clock
//   we       write enable
//   waddr    write address
//   wdata    write data (pattern byte)
//   raddr_a  / rdata_a  sequencer read port
//   raddr_b  / rdata_b  bus read port
module gpo_seq_pat_mem
  import gpo_seq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [7:0]    rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [7:0]    rdata_b
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/gpo_seq_ctrl.sv
// gpo_seq_ctrl
//   Bus-programmable pattern sequencer that masters the GPO write port.
//   The CPU loads patterns, a step length and a dwell count; the block then
//   issues one single-cycle GPO write per step, max(DWELL,1) cycles apart,
//   once or looping.
// Optional feature macro: GPO_SEQ_IRQ_EN
//   When defined, adds the irq port (done & IRQ_EN) and lets any STATUS
//   write clear done. When undefined, IRQ_EN reads back as 0.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   cs, wr, addr, wdata   slave bus write side (write when cs & wr)
//   rdata                 slave read data, combinational from addr
//   gpo_cs, gpo_wr        GPO strobes, high only in the WRITE state
//   gpo_wdata             {24'b0, pattern}, holds the last written value
//   irq                   completion interrupt (GPO_SEQ_IRQ_EN only)
module gpo_seq_ctrl
  import gpo_seq_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int DWELL_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        wr,
  input  logic [2:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        gpo_cs,
  output logic        gpo_wr,
  output logic [31:0] gpo_wdata
`ifdef GPO_SEQ_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

  seq_state_e         state_q, state_d;
  logic [PW-1:0]      idx_q, idx_d;
  logic [PW-1:0]      ptr_q;
  logic [DWELL_W-1:0] dwell_q, dwell_m1;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, eff_len;
  logic               loop_q;
  logic               irq_en_q;
  logic               done_q, done_d;
  logic [7:0]         seq_pat, bus_pat, gpo_data_q;
  logic               bus_wr, ctrl_wr, start, stop, busy;
  logic               status_clr, step_end, pat_we;
  logic               unused_wdata;

  assign bus_wr  = cs & wr;
  assign ctrl_wr = bus_wr && (addr == ADDR_CTRL);
  assign start   = ctrl_wr & wdata[CTRL_START];
  assign stop    = ctrl_wr & wdata[CTRL_STOP];
  assign busy    = (state_q != IDLE);
  assign pat_we  = bus_wr && (addr == ADDR_PAT) && !busy;

  // Not every wdata bit maps to a register field
  assign unused_wdata = &{1'b0, wdata};

  assign eff_len  = (len_q > DEPTH_L) ? DEPTH_L : len_q;
  // A dwell of 0 behaves as 1: back-to-back writes
  assign dwell_m1 = (dwell_q == '0) ? '0 : dwell_q - DWELL_W'(1);

`ifdef GPO_SEQ_IRQ_EN
  assign status_clr = bus_wr && (addr == ADDR_STATUS);
  assign irq        = done_q & irq_en_q;
`else
  assign status_clr = 1'b0;
  assign irq_en_q   = 1'b0;
`endif

  gpo_seq_pat_mem #(
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_pat_mem (
    .clk     (clk),
    .we      (pat_we),
    .waddr   (ptr_q),
    .wdata   (wdata[7:0]),
    .raddr_a (idx_q),
    .rdata_a (seq_pat),
    .raddr_b (ptr_q),
    .rdata_b (bus_pat)
  );

  // Configuration registers. LOOP/IRQ_EN stay writable while busy so a
  // looping sequence can be told to finish at its next end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loop_q  <= 1'b0;
      dwell_q <= '0;
      len_q   <= '0;
      ptr_q   <= '0;
`ifdef GPO_SEQ_IRQ_EN
      irq_en_q <= 1'b0;
`endif
    end else begin
      if (ctrl_wr) begin
        loop_q <= wdata[CTRL_LOOP];
`ifdef GPO_SEQ_IRQ_EN
        irq_en_q <= wdata[CTRL_IRQ_EN];
`endif
      end
      if (bus_wr && !busy) begin
        case (addr)
          ADDR_DWELL: dwell_q <= wdata[DWELL_W-1:0];
          ADDR_LEN:   len_q   <= wdata[LEN_W-1:0];
          ADDR_PTR:   ptr_q   <= wdata[PW-1:0];
          ADDR_PAT:   ptr_q   <= ptr_q + PW'(1);
          default:    ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      gpo_data_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      if (state_q == WRITE) begin
        gpo_data_q <= seq_pat;
      end
    end
  end

  // Next-state logic. The WRITE cycle itself counts as the first cycle of
  // the step period, so DWELL only lasts max(DWELL,1)-1 cycles and is
  // skipped entirely when the period is one cycle.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    done_d   = done_q;
    step_end = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          done_d  = 1'b0;
          idx_d   = '0;
          state_d = (eff_len == '0) ? DONE : WRITE;
        end
      end
      WRITE: begin
        cnt_d = dwell_m1;
        if (dwell_m1 == '0) begin
          step_end = 1'b1;
        end else begin
          state_d = DWELL;
        end
      end
      DWELL: begin
        cnt_d = cnt_q - DWELL_W'(1);
        if (cnt_q <= DWELL_W'(1)) begin
          step_end = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (step_end) begin
      if (LEN_W'(idx_q) < (eff_len - LEN_W'(1))) begin
        idx_d   = idx_q + PW'(1);
        state_d = WRITE;
      end else if (loop_q) begin
        idx_d   = '0;
        state_d = WRITE;
      end else begin
        state_d = DONE;
      end
    end

    if (status_clr) begin
      done_d = 1'b0;
    end
    if ((state_d == DONE) && (state_q != DONE)) begin
      done_d = 1'b1;
    end

    // STOP overrides everything, including a START in the same write
    if (stop) begin
      state_d = IDLE;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      done_d  = done_q;
    end
  end

  assign gpo_cs    = (state_q == WRITE);
  assign gpo_wr    = (state_q == WRITE);
  assign gpo_wdata = {24'b0, (state_q == WRITE) ? seq_pat : gpo_data_q};

  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_CTRL: begin
        rdata[CTRL_LOOP]   = loop_q;
        rdata[CTRL_IRQ_EN] = irq_en_q;
      end
      ADDR_STATUS: begin
        rdata[STAT_BUSY]             = busy;
        rdata[STAT_DONE]             = done_q;
        rdata[STAT_IDX_LSB +: 8]     = 8'(idx_q);
      end
      ADDR_DWELL: rdata = 32'(dwell_q);
      ADDR_LEN:   rdata = 32'(len_q);
      ADDR_PTR:   rdata = 32'(ptr_q);
      ADDR_PAT:   rdata = {24'b0, bus_pat};
      default:    rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_gpo_seq_ctrl.sv
// tb_gpo_seq_ctrl
//   Self-checking bench for gpo_seq_ctrl. Expected GPO pulses (pattern and
//   cycle) are queued when a sequence is started and compared as the DUT
//   produces them. Build with GPO_SEQ_IRQ_EN defined to cover the irq port.
module tb_gpo_seq_ctrl;
  import gpo_seq_pkg::*;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs = 1'b0;
  logic        wr = 1'b0;
  logic [2:0]  addr = 3'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        gpo_cs, gpo_wr;
  logic [31:0] gpo_wdata;
`ifdef GPO_SEQ_IRQ_EN
  logic        irq;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] pat;
    int         cyc;
  } pulse_t;
  pulse_t sb[$];

  logic [7:0] model[DEPTH];
  int model_ptr = 0;

  gpo_seq_ctrl #(.DEPTH(DEPTH), .DWELL_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .cs        (cs),
    .wr        (wr),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .gpo_cs    (gpo_cs),
    .gpo_wr    (gpo_wr),
    .gpo_wdata (gpo_wdata)
`ifdef GPO_SEQ_IRQ_EN
    ,
    .irq       (irq)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    #1;
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic readReg(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; wr = 1'b0; addr = a;
    #1;
    d = rdata;
    cs = 1'b0;
  endtask

  task automatic checkReg(input string tag, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] d;
    readReg(a, d);
    checkOutput(tag, d, exp);
  endtask

  task automatic setPtr(input int p);
    applyStimulus(ADDR_PTR, 32'(p));
    model_ptr = p;
  endtask

  task automatic writePat(input logic [7:0] v);
    applyStimulus(ADDR_PAT, {24'b0, v});
    model[model_ptr] = v;
    model_ptr = (model_ptr + 1) % DEPTH;
  endtask

  // Called right after the START write returns: first pulse is this cycle
  task automatic expectRun(input int n, input int len, input int d);
    pulse_t p;
    int base;
    base = cyc;
    for (int i = 0; i < n; i++) begin
      p.pat = model[i % len];
      p.cyc = base + i * d;
      sb.push_back(p);
    end
  endtask

  task automatic waitIdle(input int budget);
    logic [31:0] s;
    for (int i = 0; i < budget; i++) begin
      readReg(ADDR_STATUS, s);
      if (!s[STAT_BUSY]) return;
    end
    checkOutput("idle_timeout", 32'd1, 32'd0);
  endtask

  // Scoreboard consumer: every GPO pulse must match the head of the queue
  always @(negedge clk) begin
    if (gpo_cs || gpo_wr) begin
      if (sb.size() == 0) begin
        checkOutput("spurious_pulse", 32'({gpo_cs, gpo_wr}), 32'd0);
      end else begin
        pulse_t e;
        e = sb.pop_front();
        checkOutput("pulse_data", gpo_wdata, {24'b0, e.pat});
        checkOutput("pulse_cycle", 32'(cyc), 32'(e.cyc));
        checkOutput("pulse_cs_wr", 32'({gpo_cs, gpo_wr}), 32'd3);
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    checkReg("rst_ctrl", ADDR_CTRL, 32'h0);
    checkReg("rst_status", ADDR_STATUS, 32'h0);
    checkReg("rst_dwell", ADDR_DWELL, 32'h0);
    checkReg("rst_len", ADDR_LEN, 32'h0);
    checkReg("rst_ptr", ADDR_PTR, 32'h0);
    checkOutput("rst_gpo_strobe", 32'({gpo_cs, gpo_wr}), 32'd0);
    checkOutput("rst_gpo_wdata", gpo_wdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Basic one-shot run: 4 patterns, 3 cycles apart
    setPtr(0);
    writePat(8'h01); writePat(8'h02); writePat(8'h04); writePat(8'h08);
    applyStimulus(ADDR_LEN, 32'd4);
    applyStimulus(ADDR_DWELL, 32'd3);
    applyStimulus(ADDR_CTRL, 32'h1);
    expectRun(4, 4, 3);
    checkReg("busy_first", ADDR_STATUS, 32'h1);
    waitIdle(100);
    checkOutput("run1_sb_empty", 32'(sb.size()), 32'd0);
    checkReg("run1_status", ADDR_STATUS, 32'h0302);

    // PTR wraps modulo DEPTH on PAT writes
    setPtr(15);
    writePat(8'hAA);
    writePat(8'hBB);
    checkReg("ptr_wrap", ADDR_PTR, 32'd1);
    setPtr(15);
    checkReg("pat15", ADDR_PAT, 32'hAA);
    setPtr(0);
    checkReg("pat0", ADDR_PAT, 32'hBB);

    // Looping run with DWELL=0, stopped after six pulses
    applyStimulus(ADDR_LEN, 32'd2);
    applyStimulus(ADDR_DWELL, 32'd0);
    applyStimulus(ADDR_CTRL, 32'h3);
    expectRun(6, 2, 1);
    repeat (5) @(posedge clk);
    applyStimulus(ADDR_CTRL, 32'h4);
    repeat (4) @(posedge clk);
    checkOutput("loop_sb_empty", 32'(sb.size()), 32'd0);
    checkReg("stop_status", ADDR_STATUS, 32'h0100);
    checkReg("stop_ctrl", ADDR_CTRL, 32'h0);

    // LEN=0 completes immediately without a pulse
    applyStimulus(ADDR_LEN, 32'd0);
    applyStimulus(ADDR_CTRL, 32'h1);
    @(posedge clk);
    checkReg("len0_status", ADDR_STATUS, 32'h0002);

    // LEN larger than DEPTH is clamped
    setPtr(0);
    for (int i = 0; i < DEPTH; i++) writePat(8'(i * 16 + 3));
    applyStimulus(ADDR_DWELL, 32'd1);
    applyStimulus(ADDR_LEN, 32'd40);
    checkReg("len_readback", ADDR_LEN, 32'd40);
    applyStimulus(ADDR_CTRL, 32'h1);
    expectRun(DEPTH, DEPTH, 1);
    waitIdle(100);
    checkOutput("clamp_sb_empty", 32'(sb.size()), 32'd0);
    checkReg("clamp_status", ADDR_STATUS, 32'h0F02);

    // START and STOP together: STOP wins, nothing changes
    applyStimulus(ADDR_CTRL, 32'h5);
    repeat (3) @(posedge clk);
    checkReg("startstop_status", ADDR_STATUS, 32'h0F02);

    // START, PAT and PTR writes while busy are ignored
    applyStimulus(ADDR_LEN, 32'd4);
    applyStimulus(ADDR_DWELL, 32'd3);
    applyStimulus(ADDR_CTRL, 32'h1);
    expectRun(4, 4, 3);
    applyStimulus(ADDR_CTRL, 32'h1);
    applyStimulus(ADDR_PAT, 32'hEE);
    applyStimulus(ADDR_PTR, 32'd7);
    waitIdle(100);
    checkOutput("busy_sb_empty", 32'(sb.size()), 32'd0);
    checkReg("busy_ptr", ADDR_PTR, 32'(model_ptr));
    checkReg("busy_pat", ADDR_PAT, {24'b0, model[0]});
    checkReg("busy_status", ADDR_STATUS, 32'h0302);

`ifdef GPO_SEQ_IRQ_EN
    // irq follows done while IRQ_EN is set; STATUS write clears it
    applyStimulus(ADDR_CTRL, 32'h8);
    applyStimulus(ADDR_LEN, 32'd0);
    checkOutput("irq_before", 32'(irq), 32'd0);
    applyStimulus(ADDR_CTRL, 32'h9);
    @(posedge clk); #1;
    checkOutput("irq_set", 32'(irq), 32'd1);
    checkReg("irq_ctrl", ADDR_CTRL, 32'h8);
    applyStimulus(ADDR_STATUS, 32'h0);
    checkOutput("irq_clr", 32'(irq), 32'd0);
    checkReg("irq_status", ADDR_STATUS, 32'h0);
    applyStimulus(ADDR_CTRL, 32'h0);
`endif

    // Asynchronous reset in the middle of a dwell
    applyStimulus(ADDR_LEN, 32'd4);
    applyStimulus(ADDR_DWELL, 32'd10);
    applyStimulus(ADDR_CTRL, 32'h1);
    expectRun(1, 4, 10);
    repeat (4) @(posedge clk);
    #2;
    checkOutput("dwell_hold_wdata", gpo_wdata, {24'b0, model[0]});
    checkOutput("dwell_strobe", 32'({gpo_cs, gpo_wr}), 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("arst_strobe", 32'({gpo_cs, gpo_wr}), 32'd0);
    checkOutput("arst_wdata", gpo_wdata, 32'h0);
`ifdef GPO_SEQ_IRQ_EN
    checkOutput("arst_irq", 32'(irq), 32'd0);
`endif
    checkReg("arst_status", ADDR_STATUS, 32'h0);
    checkReg("arst_len", ADDR_LEN, 32'h0);
    checkReg("arst_dwell", ADDR_DWELL, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(posedge clk);
    checkOutput("arst_sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
